multi_channel_accumulator: RTL
==============================

// Module: multi_channel_accumulator
// PURPOSE
//   Parametrised successor to the single-lane tick/tock accumulator. Holds CHANNELS
//   independent ACC_W-bit accumulators and adds a per-beat addend into the addressed lane.
//   Supports wrap or saturate arithmetic, a sticky overflow flag per lane, and a drain
//   sequence that streams every lane out and clears it. Sits between a sample producer and
//   a stats/telemetry consumer.
// PARAMETERS
//   DATA_W    8  width of the in_data addend (unsigned)
//   ACC_W     16 width of each accumulator lane; must be >= DATA_W
//   CHANNELS  4  number of lanes; must be >= 2; CHAN_W = $clog2(CHANNELS)
//   SATURATE  0  0 = modulo-2^ACC_W wrap; 1 = clamp at 2^ACC_W-1
// PORTS
//   clock      in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       addend beat valid
//   in_ready   out  1       block accepts addend (state ACCUM)
//   in_chan    in   CHAN_W  target lane; values >= CHANNELS are accepted and dropped
//   in_data    in   DATA_W  unsigned addend
//   drain_req  in   1       pulse/level: start a drain sequence
//   out_valid  out  1       drained lane result valid
//   out_ready  in   1       consumer accepts result
//   out_chan   out  CHAN_W  lane index of current result
//   out_data   out  ACC_W   lane value
//   out_ovf    out  1       lane sticky overflow flag
//   busy       out  1       high in DRAIN state
// BEHAVIOUR
//   Reset (async, rst_n=0): all lanes 0, all ovf 0, state ACCUM, in_ready=1,
//     out_valid=0, out_chan=0, out_data=0, out_ovf=0, busy=0. Reset mid-drain aborts it.
//   FSM: ACCUM -> DRAIN when drain_req=1 at a clock edge; DRAIN -> ACCUM after lane
//     CHANNELS-1 handshakes. drain_req ignored while in DRAIN.
//   ACCUM: in_ready=1. Beat accepted on in_valid&in_ready; lane updated on that edge
//     (1-cycle latency, visible next cycle). Addend zero-extended to ACC_W+1 for the sum.
//   Wrap: lane <= sum[ACC_W-1:0]; ovf <= ovf | sum[ACC_W].
//   Saturate: if sum[ACC_W] lane <= all-ones, ovf <= 1; else lane <= sum.
//   Lane at all-ones + 0 -> unchanged, no ovf. Out-of-range in_chan: beat consumed, no effect.
//   Simultaneous accept + drain_req in ACCUM: beat applied on same edge; drain starts next
//     cycle and includes it.
//   DRAIN: in_ready=0, busy=1. Index ptr starts 0; out_valid=1 from first DRAIN cycle;
//     out_chan=ptr, out_data/out_ovf are registered copies of lane[ptr] (stable while
//     out_valid&!out_ready). On out_valid&out_ready: lane[ptr] and ovf[ptr] cleared,
//     ptr increments; last handshake returns to ACCUM with out_valid=0 next cycle.
//     Back-to-back handshakes give one lane per cycle; drain of N lanes takes >= N cycles.
//   out_valid must not depend combinationally on out_ready.
// STRUCTURE
//   Package acc_pkg: state_e {ACCUM, DRAIN}; localparam CHAN_W function; lane-result
//     struct {chan, data, ovf}.
//   Sub-module acc_lane (one instance per channel, generate loop): holds value + ovf,
//     inputs add_en, addend, clear; parameters ACC_W, SATURATE. Top holds FSM, decode, mux.
// TESTING
//   1 Reset then 3 beats chan1 data 0x10 -> drain yields lane0..3 = 0,0x30,0,0; ovf all 0.
//   2 ACC_W=8 wrap: chan0 beats 0xF0,0x20 -> drain chan0 data 0x10 ovf 1; after drain 0.
//   3 SATURATE=1, ACC_W=8: chan2 beats 0xF0,0x20,0x05 -> data 0xFF ovf 1.
//   4 Drain with out_ready low 3 cycles on lane1 -> out_data stable, in_ready=0, in_valid
//     beats ignored (lane unchanged), drain completes in order 0..3, then in_ready=1.
//   5 in_valid chan3 data 7 same edge as drain_req -> drained chan3 = 7.
//   6 rst_n low mid-drain at lane2 -> immediate out_valid=0, busy=0; subsequent drain all 0.
//     Also: in_chan=5 with CHANNELS=5 -> no lane changes.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and helpers for the multi-channel accumulator.
package acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Lane-index width; a single-lane build still needs one bit of index.
  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: value plus sticky overflow, wrap or saturate on add.
// Next-state values are exported so the parent can register a snapshot on the same edge.
module acc_lane
#(
  parameter int ACC_W    = 16,
  parameter int SATURATE = 0
)
(
  input  logic             clock,
  input  logic             rst_n,
  input  logic             add_en,
  input  logic [ACC_W-1:0] addend,
  input  logic             clear,
  output logic [ACC_W-1:0] o_value_nxt,
  output logic             o_ovf_nxt
);

  logic [ACC_W-1:0] r_value;
  logic             r_ovf;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_value} + {1'b0, addend};

  // Clear and add never coincide: clear only happens while draining, add only while accumulating.
  always_comb begin
    o_value_nxt = r_value;
    o_ovf_nxt   = r_ovf;
    if (clear) begin
      o_value_nxt = '0;
      o_ovf_nxt   = 1'b0;
    end else if (add_en) begin
      if ((SATURATE != 0) && w_sum[ACC_W]) begin
        o_value_nxt = '1;
        o_ovf_nxt   = 1'b1;
      end else begin
        o_value_nxt = w_sum[ACC_W-1:0];
        o_ovf_nxt   = r_ovf | w_sum[ACC_W];
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_value <= o_value_nxt;
      r_ovf   <= o_ovf_nxt;
    end
  end

endmodule

// File: rtl/multi_channel_accumulator.sv
// CHANNELS independent accumulators fed by addressed beats; a drain streams every lane out
// (one per handshake, registered output) and clears it. Inputs are stalled while draining.
module multi_channel_accumulator
  import acc_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int ACC_W    = 16,
  parameter  int CHANNELS = 4,
  parameter  int SATURATE = 0,
  localparam int CHAN_W   = chan_w(CHANNELS)
)
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAN_W-1:0] out_chan,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              busy
);

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [ACC_W-1:0]  data;
    logic              ovf;
  } lane_res_t;

  state_e            r_state, w_state_nxt;
  logic [CHAN_W-1:0] r_ptr, w_ptr_nxt;
  lane_res_t         r_res, w_res_nxt;

  logic                w_accept;
  logic                w_out_hs;
  logic                w_last;
  logic [ACC_W-1:0]    w_addend;
  logic [CHANNELS-1:0] w_add_en;
  logic [CHANNELS-1:0] w_clear;
  logic [ACC_W-1:0]    w_lane_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_ovf_nxt;

  assign in_ready  = (r_state == ACCUM);
  assign busy      = (r_state == DRAIN);
  assign out_valid = (r_state == DRAIN);
  assign out_chan  = r_res.chan;
  assign out_data  = r_res.data;
  assign out_ovf   = r_res.ovf;

  assign w_accept = in_valid & in_ready;
  assign w_out_hs = out_valid & out_ready;
  assign w_last   = (r_ptr == CHAN_W'(CHANNELS - 1));
  assign w_addend = ACC_W'(in_data);

  // Out-of-range lane indices match no decoder output, so such beats are consumed silently.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign w_add_en[g] = w_accept && (in_chan == CHAN_W'(g));
    assign w_clear[g]  = w_out_hs && (r_ptr == CHAN_W'(g));

    acc_lane #(
      .ACC_W    (ACC_W),
      .SATURATE (SATURATE)
    ) u_lane (
      .clock       (clock),
      .rst_n       (rst_n),
      .add_en      (w_add_en[g]),
      .addend      (w_addend),
      .clear       (w_clear[g]),
      .o_value_nxt (w_lane_nxt[g]),
      .o_ovf_nxt   (w_ovf_nxt[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ACCUM: begin
        if (drain_req) begin
          w_state_nxt = DRAIN;
          w_ptr_nxt   = '0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (w_last) begin
            w_state_nxt = ACCUM;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + CHAN_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ACCUM;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Snapshot the lane's next value so a beat landing on the drain_req edge is included.
  always_comb begin
    w_res_nxt = '0;
    if (w_state_nxt == DRAIN) begin
      w_res_nxt.chan = w_ptr_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_ptr_nxt == CHAN_W'(i)) begin
          w_res_nxt.data = w_lane_nxt[i];
          w_res_nxt.ovf  = w_ovf_nxt[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_ptr   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_res   <= w_res_nxt;
    end
  end

endmodule
